// File: rtl/pcs_link_ctrl.sv
// PCS link controller: WAIT_SYNC -> CONFIG_TX -> IDLE_TX -> LINK_OK bring-up with timed phases.
// Optional link-drop counter enabled by defining PCS_LINK_CTRL_STATS_EN.
module pcs_link_ctrl #(
  parameter int unsigned LINK_TIMER_W      = 16,
  parameter int unsigned LINK_TIMER_CYCLES = 1000
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       code_sync_status,
  input  logic       signal_detect,
  input  logic       mr_restart,
  input  logic       transmitting,
  output logic [2:0] xmit,
  output logic       link_ok,
  output logic [1:0] state
`ifdef PCS_LINK_CTRL_STATS_EN
  ,
  output logic [7:0] link_drops
`endif
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    CONFIG_TX = 2'd1,
    IDLE_TX   = 2'd2,
    LINK_OK   = 2'd3
  } state_e;

  localparam logic [LINK_TIMER_W-1:0] TIMER_LAST = LINK_TIMER_W'(LINK_TIMER_CYCLES - 1);

  localparam logic [2:0] XMIT_CONFIG = 3'b001;
  localparam logic [2:0] XMIT_IDLE   = 3'b010;
  localparam logic [2:0] XMIT_DATA   = 3'b100;

  state_e                  state_q, state_d;
  logic [LINK_TIMER_W-1:0] timer_q, timer_d;
  logic                    restart_pend_q, restart_pend_d;
  logic                    good;

  assign good = code_sync_status & signal_detect;

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q        <= WAIT_SYNC;
      timer_q        <= '0;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = '0;
    restart_pend_d = 1'b0;
    case (state_q)
      WAIT_SYNC: begin
        if (!mr_restart && good) state_d = CONFIG_TX;
      end
      CONFIG_TX: begin
        if (mr_restart || !good)     state_d = WAIT_SYNC;
        else if (timer_q == TIMER_LAST) state_d = IDLE_TX;
        else                         timer_d = timer_q + 1'b1;
      end
      IDLE_TX: begin
        if (mr_restart || !good)     state_d = WAIT_SYNC;
        else if (timer_q == TIMER_LAST) state_d = LINK_OK;
        else                         timer_d = timer_q + 1'b1;
      end
      LINK_OK: begin
        // A restart seen mid-packet is remembered and honoured once transmitting drops.
        if (!good)
          state_d = WAIT_SYNC;
        else if ((mr_restart || restart_pend_q) && !transmitting)
          state_d = WAIT_SYNC;
        else
          restart_pend_d = restart_pend_q | mr_restart;
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_comb begin
    xmit    = XMIT_CONFIG;
    link_ok = 1'b0;
    state   = state_q;
    case (state_q)
      IDLE_TX: xmit = XMIT_IDLE;
      LINK_OK: begin
        xmit    = XMIT_DATA;
        link_ok = 1'b1;
      end
      default: xmit = XMIT_CONFIG;
    endcase
  end

`ifdef PCS_LINK_CTRL_STATS_EN
  logic [7:0] link_drops_q, link_drops_d;

  always_comb begin
    link_drops_d = link_drops_q;
    if (state_q == LINK_OK && state_d == WAIT_SYNC && link_drops_q != 8'hFF)
      link_drops_d = link_drops_q + 8'd1;
  end

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) link_drops_q <= '0;
    else               link_drops_q <= link_drops_d;
  end

  assign link_drops = link_drops_q;
`endif

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Directed self-checking bench for pcs_link_ctrl with LINK_TIMER_CYCLES=4.
module tb_pcs_link_ctrl;

  logic       GTX_CLK = 1'b0;
  logic       mr_main_reset = 1'b0;
  logic       code_sync_status = 1'b0;
  logic       signal_detect = 1'b0;
  logic       mr_restart = 1'b0;
  logic       transmitting = 1'b0;
  logic [2:0] xmit;
  logic       link_ok;
  logic [1:0] state;
`ifdef PCS_LINK_CTRL_STATS_EN
  logic [7:0] link_drops;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pcs_link_ctrl #(
    .LINK_TIMER_W     (16),
    .LINK_TIMER_CYCLES(4)
  ) dut (
    .GTX_CLK         (GTX_CLK),
    .mr_main_reset   (mr_main_reset),
    .code_sync_status(code_sync_status),
    .signal_detect   (signal_detect),
    .mr_restart      (mr_restart),
    .transmitting    (transmitting),
    .xmit            (xmit),
    .link_ok         (link_ok),
    .state           (state)
`ifdef PCS_LINK_CTRL_STATS_EN
    ,
    .link_drops      (link_drops)
`endif
  );

  always #5 GTX_CLK = ~GTX_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge GTX_CLK);
      #1;
    end
  endtask

  // Raise good from WAIT_SYNC and walk the 4+4 cycle bring-up into LINK_OK.
  task automatic bringup(input bit do_check);
    logic [1:0] exp_st;
    logic [2:0] exp_x;
    code_sync_status = 1'b1;
    signal_detect    = 1'b1;
    for (int unsigned i = 1; i <= 9; i++) begin
      tick();
      exp_st = (i <= 4) ? 2'd1 : (i <= 8) ? 2'd2 : 2'd3;
      exp_x  = (exp_st == 2'd1) ? 3'b001 : (exp_st == 2'd2) ? 3'b010 : 3'b100;
      if (do_check) begin
        check($sformatf("bringup_state_e%0d", i), {30'd0, state}, {30'd0, exp_st});
        check($sformatf("bringup_xmit_e%0d", i), {29'd0, xmit}, {29'd0, exp_x});
        check($sformatf("bringup_linkok_e%0d", i), {31'd0, link_ok}, {31'd0, exp_st == 2'd3});
      end
    end
  endtask

  initial begin
    // Reset state, visible before any clock edge
    #1 mr_main_reset = 1'b1;
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_xmit", {29'd0, xmit}, 32'd1);
    check("rst_linkok", {31'd0, link_ok}, 32'd0);
`ifdef PCS_LINK_CTRL_STATS_EN
    check("rst_drops", {24'd0, link_drops}, 32'd0);
`endif
    tick(2);
    mr_main_reset = 1'b0;
    tick();
    check("idle_no_good", {30'd0, state}, 32'd0);

    bringup(1'b1);
    tick(3);
    check("linkok_hold", {30'd0, state}, 32'd3);

    // Loss of good in LINK_OK
    code_sync_status = 1'b0;
    tick();
    check("linkok_loss_state", {30'd0, state}, 32'd0);
    check("linkok_loss_linkok", {31'd0, link_ok}, 32'd0);

    // Loss in the 2nd IDLE_TX cycle
    code_sync_status = 1'b1;
    tick(5);
    check("idle1_state", {30'd0, state}, 32'd2);
    tick();
    check("idle2_state", {30'd0, state}, 32'd2);
    code_sync_status = 1'b0;
    tick();
    check("idle_loss_state", {30'd0, state}, 32'd0);
    check("idle_loss_xmit", {29'd0, xmit}, 32'd1);
    bringup(1'b1);

    // Good drops exactly when the CONFIG_TX timer reaches its last value
    signal_detect = 1'b0;
    tick();
    signal_detect = 1'b1;
    tick(4);
    check("cfg_last_state", {30'd0, state}, 32'd1);
    signal_detect = 1'b0;
    tick();
    check("simul_loss_state", {30'd0, state}, 32'd0);
    tick();
    check("simul_loss_stay", {30'd0, state}, 32'd0);

    // Restart held high keeps WAIT_SYNC even with good
    signal_detect = 1'b1;
    mr_restart    = 1'b1;
    tick(3);
    check("restart_hold", {30'd0, state}, 32'd0);
    mr_restart = 1'b0;
    tick(2);
    check("restart_release", {30'd0, state}, 32'd1);
    mr_restart = 1'b1;
    tick();
    check("restart_cfg", {30'd0, state}, 32'd0);
    mr_restart = 1'b0;
    bringup(1'b0);
    check("relink_state", {30'd0, state}, 32'd3);

    // Deferred restart: one-cycle pulse while transmitting
    transmitting = 1'b1;
    mr_restart   = 1'b1;
    tick();
    mr_restart = 1'b0;
    check("defer_c1", {30'd0, state}, 32'd3);
    for (int unsigned i = 2; i <= 5; i++) begin
      tick();
      check($sformatf("defer_c%0d", i), {30'd0, state}, 32'd3);
    end
    transmitting = 1'b0;
    tick();
    check("defer_done_state", {30'd0, state}, 32'd0);
    check("defer_done_linkok", {31'd0, link_ok}, 32'd0);

    // Restart in LINK_OK without traffic acts at once; loss of good never deferred
    bringup(1'b0);
    mr_restart = 1'b1;
    tick();
    mr_restart = 1'b0;
    check("restart_now", {30'd0, state}, 32'd0);
    bringup(1'b0);
    transmitting     = 1'b1;
    code_sync_status = 1'b0;
    tick();
    check("loss_while_tx", {30'd0, state}, 32'd0);
    transmitting     = 1'b0;
    code_sync_status = 1'b1;
    tick();
    tick();
    check("pend_cleared", {30'd0, state}, 32'd1);

    // Asynchronous reset between edges in LINK_OK
    signal_detect = 1'b0;
    tick();
    bringup(1'b0);
    check("pre_async", {31'd0, link_ok}, 32'd1);
    #2 mr_main_reset = 1'b1;
    #1;
    check("async_linkok", {31'd0, link_ok}, 32'd0);
    check("async_xmit", {29'd0, xmit}, 32'd1);
    check("async_state", {30'd0, state}, 32'd0);
    mr_main_reset = 1'b0;
    tick();
    check("post_rst_state", {30'd0, state}, 32'd1);

`ifdef PCS_LINK_CTRL_STATS_EN
    mr_main_reset = 1'b1;
    #1 check("stats_rst", {24'd0, link_drops}, 32'd0);
    mr_main_reset = 1'b0;
    code_sync_status = 1'b0;
    tick();
    for (int unsigned i = 1; i <= 300; i++) begin
      bringup(1'b0);
      if (i[0]) code_sync_status = 1'b0;
      else      mr_restart       = 1'b1;
      tick();
      mr_restart = 1'b0;
      code_sync_status = 1'b0;
      if (i == 1) check("stats_one", {24'd0, link_drops}, 32'd1);
      if (i == 2) check("stats_two", {24'd0, link_drops}, 32'd2);
    end
    check("stats_sat", {24'd0, link_drops}, 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
